// File: rtl/minterm_sweep_lut_if.sv
// Bus bundle for minterm_sweep_lut: LUT configuration, point evaluation and sweep reporting.
// The dump stream signals exist only when MINTERM_SWEEP_DUMP_EN is defined.
interface minterm_sweep_lut_if #(
  parameter int N_IN = 4
);
  localparam int DEPTH = 1 << N_IN;

  logic              cfg_we;
  logic [N_IN-1:0]   cfg_addr;
  logic              cfg_data;
  logic              cfg_clear;
  logic              eval_valid;
  logic [N_IN-1:0]   eval_in;
  logic              eval_ready;
  logic              res_valid;
  logic              res_out;
  logic              sweep_start;
  logic              sweep_busy;
  logic              sweep_done;
  logic [N_IN:0]     minterm_count;
  logic [DEPTH-1:0]  sweep_vec;
`ifdef MINTERM_SWEEP_DUMP_EN
  logic              dump_valid;
  logic [N_IN-1:0]   dump_idx;
  logic              dump_bit;
`endif

  modport master (
    output cfg_we, cfg_addr, cfg_data, cfg_clear,
    output eval_valid, eval_in, sweep_start,
    input  eval_ready, res_valid, res_out,
    input  sweep_busy, sweep_done, minterm_count, sweep_vec
`ifdef MINTERM_SWEEP_DUMP_EN
    , input dump_valid, dump_idx, dump_bit
`endif
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_data, cfg_clear,
    input  eval_valid, eval_in, sweep_start,
    output eval_ready, res_valid, res_out,
    output sweep_busy, sweep_done, minterm_count, sweep_vec
`ifdef MINTERM_SWEEP_DUMP_EN
    , output dump_valid, dump_idx, dump_bit
`endif
  );
endinterface

// File: rtl/minterm_sweep_lut.sv
// Programmable sum-of-minterms evaluator: writable truth table, 1-cycle point evaluation,
// and a sweep engine reporting minterm count and function vector. MINTERM_SWEEP_DUMP_EN adds a truth-table stream.
module minterm_sweep_lut #(
  parameter int N_IN = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  minterm_sweep_lut_if.slave   bus
);
  localparam int DEPTH = 1 << N_IN;
  localparam logic [N_IN-1:0] IDX_LAST = N_IN'(DEPTH - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SWEEP = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [DEPTH-1:0] lut_q, lut_d;
  logic [N_IN-1:0]  idx_q, idx_d;
  logic [N_IN:0]    cnt_acc_q, cnt_acc_d;
  logic [DEPTH-1:0] vec_acc_q, vec_acc_d;
  logic [N_IN:0]    count_q, count_d;
  logic [DEPTH-1:0] vec_q, vec_d;
  logic             res_valid_q, res_valid_d;
  logic             res_out_q, res_out_d;
  logic             lut_bit;
  logic             in_idle;
  logic             eval_ready;
  logic             eval_accept;

  assign in_idle     = (state_q == ST_IDLE);
  assign lut_bit     = lut_q[idx_q];
  // Held low during reset so the handshake only opens once the block is live.
  assign eval_ready  = rst_n & in_idle & ~bus.sweep_start;
  assign eval_accept = bus.eval_valid & eval_ready;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_acc_d   = cnt_acc_q;
    vec_acc_d   = vec_acc_q;
    count_d     = count_q;
    vec_d       = vec_q;
    lut_d       = lut_q;
    res_valid_d = eval_accept;
    res_out_d   = eval_accept ? lut_q[bus.eval_in] : res_out_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.sweep_start) begin
          state_d   = ST_SWEEP;
          idx_d     = '0;
          cnt_acc_d = '0;
          vec_acc_d = '0;
        end
      end
      ST_SWEEP: begin
        vec_acc_d[idx_q] = lut_bit;
        cnt_acc_d        = cnt_acc_q + {{N_IN{1'b0}}, lut_bit};
        idx_d            = idx_q + 1'b1;
        // Results are published on the final read so they are stable while sweep_done pulses.
        if (idx_q == IDX_LAST) begin
          state_d = ST_DONE;
          count_d = cnt_acc_d;
          vec_d   = vec_acc_d;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    if (in_idle) begin
      if (bus.cfg_clear)   lut_d = '0;
      else if (bus.cfg_we) lut_d[bus.cfg_addr] = bus.cfg_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      lut_q       <= '0;
      idx_q       <= '0;
      cnt_acc_q   <= '0;
      vec_acc_q   <= '0;
      count_q     <= '0;
      vec_q       <= '0;
      res_valid_q <= 1'b0;
      res_out_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      lut_q       <= lut_d;
      idx_q       <= idx_d;
      cnt_acc_q   <= cnt_acc_d;
      vec_acc_q   <= vec_acc_d;
      count_q     <= count_d;
      vec_q       <= vec_d;
      res_valid_q <= res_valid_d;
      res_out_q   <= res_out_d;
    end
  end

  assign bus.eval_ready    = eval_ready;
  assign bus.res_valid     = res_valid_q;
  assign bus.res_out       = res_out_q;
  assign bus.sweep_busy    = (state_q == ST_SWEEP) | (state_q == ST_DONE);
  assign bus.sweep_done    = (state_q == ST_DONE);
  assign bus.minterm_count = count_q;
  assign bus.sweep_vec     = vec_q;

`ifdef MINTERM_SWEEP_DUMP_EN
  logic            dump_valid_q;
  logic [N_IN-1:0] dump_idx_q;
  logic            dump_bit_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dump_valid_q <= 1'b0;
      dump_idx_q   <= '0;
      dump_bit_q   <= 1'b0;
    end else begin
      dump_valid_q <= (state_q == ST_SWEEP);
      dump_idx_q   <= idx_q;
      dump_bit_q   <= lut_bit;
    end
  end

  assign bus.dump_valid = dump_valid_q;
  assign bus.dump_idx   = dump_idx_q;
  assign bus.dump_bit   = dump_bit_q;
`endif
endmodule

// File: doc/minterm_sweep_lut.md
Name: minterm_sweep_lut

Overview:
- Parametrised, programmable sum-of-minterms evaluator.
- The Boolean function is held in a writable truth-table register (LUT), one bit per minterm index.
- Single-point evaluation uses a valid/ready handshake with a registered result.
- A sweep engine walks all 2^N_IN input combinations and reports the minterm count and the full function vector.
- Serves as the reusable function block for the logic-minimisation exercises, replacing hard-wired SOP expressions.

Parameters:
- N_IN, 4, number of function inputs; legal range 1..6.
- DEPTH, 2**N_IN, LUT size; derived, not overridable.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous reset, active-low
- cfg_we  in  1  write one LUT bit this cycle
- cfg_addr  in  N_IN  minterm index to write
- cfg_data  in  1  value written (1 = minterm present)
- cfg_clear  in  1  clear entire LUT this cycle
- eval_valid  in  1  evaluation request
- eval_in  in  N_IN  input vector; MSB is the first variable (a)
- eval_ready  out  1  request can be accepted
- res_valid  out  1  one-cycle pulse, result valid
- res_out  out  1  function value for the accepted eval_in
- sweep_start  in  1  start full enumeration
- sweep_busy  out  1  sweep in progress
- sweep_done  out  1  one-cycle pulse at end of sweep
- minterm_count  out  N_IN+1  number of 1 entries found by the last sweep
- sweep_vec  out  DEPTH  function vector captured by the last sweep; bit i = f(i)

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - LUT = 0, FSM = IDLE, index = 0.
  - All outputs 0, except eval_ready = 1 from the first cycle after reset.
- FSM states: IDLE -> SWEEP -> DONE -> IDLE.
  - IDLE -> SWEEP: on sweep_start=1. Clears the count accumulator and the vector accumulator; sets index = 0.
  - SWEEP: one LUT entry read per cycle.
    - Accumulator bit[index] <= LUT[index].
    - Count accumulator += LUT[index].
    - index++.
  - SWEEP -> DONE: after index DEPTH-1 is processed. The sweep takes exactly DEPTH cycles in SWEEP.
  - DONE: lasts one cycle.
    - sweep_done = 1.
    - minterm_count and sweep_vec load from the accumulators.
    - Next state is IDLE.
- sweep_busy = 1 in SWEEP and DONE.
- minterm_count and sweep_vec hold their values until the next DONE. Width N_IN+1, so count = DEPTH is representable.
- Evaluation:
  - eval_ready = 1 only in IDLE and when sweep_start=0 in the same cycle.
  - A request is accepted when eval_valid & eval_ready.
  - Latency is 1: the next cycle shows res_valid=1 and res_out=LUT[eval_in].
  - Back-to-back accepts give back-to-back res_valid pulses.
  - With no accept, res_valid=0 and res_out holds its last value.
- Configuration:
  - cfg_we and cfg_clear take effect at the clock edge only in IDLE. They are silently ignored while sweep_busy=1, so the captured vector stays consistent.
  - cfg_clear has priority over cfg_we in the same cycle.
- Simultaneous events:
  - eval accepted in the same cycle as a cfg_we to the same address: res_out returns the OLD LUT value (read-before-write).
  - sweep_start together with eval_valid in IDLE: sweep wins and the eval is not accepted (eval_ready=0).
  - sweep_start while busy: ignored.
  - cfg writes in the same cycle as sweep_start: applied, because the FSM is still in IDLE. The sweep sees the new values.
- Reset during SWEEP: FSM returns to IDLE and the LUT is cleared. No sweep_done pulse is generated. minterm_count and sweep_vec are reset to 0.

Optional Feature:
- Macro: MINTERM_SWEEP_DUMP_EN.
- Defined: adds three outputs.
  - dump_valid  out  1
  - dump_idx  out  N_IN
  - dump_bit  out  1
  - In each SWEEP cycle: dump_valid=1, dump_idx=index, dump_bit=LUT[index], registered and aligned with the accumulator update.
  - Outside SWEEP: dump_valid=0.
  - Purpose: streams the truth table to a bench monitor or display block.
- Undefined: these ports and their logic do not exist. All other behaviour is identical.

Test Plan:
- Reset, then write 1 to indices 7, 10, 11, 13 (function ab~cd + ~abcd + a~bcd + a~bc), then sweep_start -> sweep_busy high for exactly 16+1 cycles; sweep_done pulse; minterm_count=4; sweep_vec=16'h2C80.
- Same LUT, evaluate all 16 eval_in values back-to-back with eval_valid held high -> 16 consecutive res_valid pulses; res_out=1 exactly for inputs 7, 10, 11, 13.
- During a sweep, assert cfg_we addr 0 data 1 and cfg_clear -> both ignored; count stays 4; a following eval of 0 returns 0.
- Same-cycle eval of index 13 and cfg_we addr 13 data 0 -> res_out=1. A subsequent eval of 13 -> 0.
- Pull rst_n low in SWEEP cycle 5 -> no sweep_done; next cycle busy=0, count=0, sweep_vec=0, eval of 7 returns 0.
- Boundaries: cfg_clear then sweep -> count=0. Write all 16 entries to 1 then sweep -> count=16 (5'b10000). With MINTERM_SWEEP_DUMP_EN, dump_idx runs 0..15 with dump_bit matching the LUT.
